// File: rtl/apb_wb_bridge.sv
// APB3/APB4 slave to pipelined Wishbone B4 master bridge.
// Single outstanding transfer, registered request/response, optional byte-swap window and timeout.
module apb_wb_bridge #(
  parameter int unsigned           ADDR_WIDTH    = 5,
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           WB_ADDR_WIDTH = ADDR_WIDTH - $clog2(DATA_WIDTH / 8),
  parameter logic [ADDR_WIDTH-1:0] SWAP_MASK     = '0,
  parameter logic [ADDR_WIDTH-1:0] SWAP_BASE     = '0,
  parameter int unsigned           TIMEOUT       = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      apb_PADDR,
  input  logic                       apb_PSEL,
  input  logic                       apb_PENABLE,
  input  logic                       apb_PWRITE,
  input  logic [DATA_WIDTH-1:0]      apb_PWDATA,
  input  logic [DATA_WIDTH/8-1:0]    apb_PSTRB,
  output logic                       apb_PREADY,
  output logic [DATA_WIDTH-1:0]      apb_PRDATA,
  output logic                       apb_PSLVERR,
  output logic                       wb_cyc,
  output logic                       wb_stb,
  output logic                       wb_we,
  output logic [WB_ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH-1:0]      wb_dat_w,
  output logic [DATA_WIDTH/8-1:0]    wb_sel,
  input  logic [DATA_WIDTH-1:0]      wb_dat_r,
  input  logic                       wb_ack,
  input  logic                       wb_err,
  input  logic                       wb_stall
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF   = $clog2(NB);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     swap_q;
  logic                     cyc_q;
  logic                     stb_q;
  logic                     we_q;
  logic [WB_ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0]    dat_w_q;
  logic [NB-1:0]            sel_q;
  logic                     pready_q;
  logic                     pslverr_q;
  logic [DATA_WIDTH-1:0]    prdata_q;

  logic                     swap_hit_c;
  logic [NB-1:0]            sel_c;
  logic                     rsp_c;
  logic                     tmo_c;
  logic [DATA_WIDTH-1:0]    rd_data_c;

  function automatic logic [DATA_WIDTH-1:0] byte_rev(input logic [DATA_WIDTH-1:0] d);
    for (int i = 0; i < int'(NB); i++) byte_rev[8*i +: 8] = d[8*(int'(NB)-1-i) +: 8];
  endfunction

  function automatic logic [NB-1:0] bit_rev(input logic [NB-1:0] s);
    for (int i = 0; i < int'(NB); i++) bit_rev[i] = s[int'(NB)-1-i];
  endfunction

  assign swap_hit_c = (SWAP_MASK != '0) && ((apb_PADDR & SWAP_MASK) == SWAP_BASE);
  assign sel_c      = apb_PWRITE ? apb_PSTRB : {NB{1'b1}};
  // A response only counts once the request has been accepted (not stalled).
  assign rsp_c      = (wb_ack || wb_err) &&
                      ((state_q == S_WAIT) || ((state_q == S_REQ) && !wb_stall));
  assign tmo_c      = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
  assign rd_data_c  = swap_q ? byte_rev(wb_dat_r) : wb_dat_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      swap_q    <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_w_q   <= '0;
      sel_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (apb_PSEL && apb_PENABLE) begin
            state_q <= S_REQ;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= apb_PWRITE;
            adr_q   <= WB_ADDR_WIDTH'(apb_PADDR >> OFF);
            swap_q  <= swap_hit_c;
            dat_w_q <= swap_hit_c ? byte_rev(apb_PWDATA) : apb_PWDATA;
            sel_q   <= swap_hit_c ? bit_rev(sel_c) : sel_c;
            cnt_q   <= '0;
          end
        end
        S_REQ, S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (rsp_c) begin
            state_q   <= S_DONE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= wb_err;
            prdata_q  <= (!wb_err && !we_q) ? rd_data_c : '0;
          end else if (tmo_c) begin
            state_q   <= S_DONE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
          end else if ((state_q == S_REQ) && !wb_stall) begin
            state_q <= S_WAIT;
            stb_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign apb_PREADY  = pready_q;
  assign apb_PRDATA  = prdata_q;
  assign apb_PSLVERR = pslverr_q;
  assign wb_cyc      = cyc_q;
  assign wb_stb      = stb_q;
  assign wb_we       = we_q;
  assign wb_adr      = adr_q;
  assign wb_dat_w    = dat_w_q;
  assign wb_sel      = sel_q;

endmodule

// File: doc/apb_wb_bridge.md
# apb_wb_bridge

- Parametrised APB3/APB4 slave to pipelined Wishbone B4 master bridge.
- Sits between the SoC APB interconnect and any Wishbone-register peripheral (SD card, future DMA/flash controllers). It replaces per-peripheral glue logic.
- Adds over that glue logic:
  - configurable data/address width;
  - mask-selected byte-reversal window;
  - PSTRB-driven byte selects;
  - registered request/response stages;
  - bus-error and timeout reporting via PSLVERR.

## Interface

Parameters:
- ADDR_WIDTH, 5: APB byte-address width.
- DATA_WIDTH, 32: data width; a multiple of 8, range 8..64.
- WB_ADDR_WIDTH, ADDR_WIDTH-log2(DATA_WIDTH/8): Wishbone word-address width.
- SWAP_MASK, 0: PADDR bits compared for the swap window. 0 disables swapping.
- SWAP_BASE, 0: swap window is active when (PADDR & SWAP_MASK) == SWAP_BASE, with SWAP_MASK != 0.
- TIMEOUT, 255: maximum cycles from request issue to ack/err. 0 disables the timeout.

Ports:
- clk, input, 1: sole clock.
- reset, input, 1: synchronous, active-high.
- apb_PADDR, input, ADDR_WIDTH: byte address.
- apb_PSEL / apb_PENABLE / apb_PWRITE, input, 1 each: APB control.
- apb_PWDATA, input, DATA_WIDTH: write data.
- apb_PSTRB, input, DATA_WIDTH/8: write byte strobes. Tie to all-ones for APB3 masters.
- apb_PREADY, output, 1: transfer complete.
- apb_PRDATA, output, DATA_WIDTH: read data.
- apb_PSLVERR, output, 1: error response.
- wb_cyc / wb_stb / wb_we, output, 1 each: Wishbone control.
- wb_adr, output, WB_ADDR_WIDTH: PADDR[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
- wb_dat_w, output, DATA_WIDTH: write data.
- wb_sel, output, DATA_WIDTH/8: byte selects.
- wb_dat_r, input, DATA_WIDTH: read data.
- wb_ack / wb_err / wb_stall, input, 1 each: Wishbone response and flow control.

## Operation

- Single outstanding transaction.
- FSM states: IDLE, REQ, WAIT, DONE.

IDLE:
- On apb_PSEL & apb_PENABLE, latch the following and go to REQ:
  - address;
  - we;
  - swap flag from the window compare;
  - write data;
  - sel: PSTRB for writes, all-ones for reads.
- If the swap flag is set, byte-reverse the write data and bit-reverse sel at latch time.
- Clear the timeout counter.

REQ:
- wb_cyc=1, wb_stb=1.
- If wb_stall=0, the request is accepted:
  - wb_ack or wb_err in the same cycle goes directly to DONE (combinational-ack slaves are tolerated);
  - otherwise go to WAIT.
- If wb_stall=1, stay in REQ with stb held and all request fields stable.

WAIT:
- wb_cyc=1, wb_stb=0.
- wb_ack goes to DONE with PSLVERR=0.
- wb_err goes to DONE with PSLVERR=1.
- If ack and err are both high, err wins.

DONE:
- apb_PREADY=1 for exactly one cycle, then go to IDLE.
- wb_cyc=0.

Response data:
- apb_PRDATA and apb_PSLVERR are registered on entry to DONE.
- On a read ack, PRDATA = wb_dat_r, byte-reversed if the swap flag is set.
- On write, error, or timeout, PRDATA = 0.

Timeout:
- The counter increments every cycle in REQ or WAIT.
- If the counter equals TIMEOUT and neither ack nor err arrives that cycle:
  - drop wb_cyc and wb_stb;
  - go to DONE with PSLVERR=1 and PRDATA=0.
- Late acks arriving in IDLE are ignored.

Protocol violations:
- If the APB master deasserts PSEL mid-transaction, the Wishbone cycle still completes and the PREADY pulse is still emitted.
- A new access is only recognised in IDLE.

Reset:
- Takes effect in any state, including mid-cycle.
- Next cycle: state IDLE, wb_cyc=0, wb_stb=0, apb_PREADY=0, apb_PSLVERR=0, apb_PRDATA=0, wb_we=0, wb_adr=0, wb_sel=0, wb_dat_w=0, counter=0.

## Timing

- T denotes the first cycle with PSEL & PENABLE observed in IDLE.
- All outputs are registered; there is no combinational path from APB inputs to Wishbone outputs.
- wb_cyc and wb_stb rise at T+1.
- Minimum latency:
  - ack in the same cycle as acceptance (T+1): PREADY at T+2;
  - ack one cycle after acceptance (T+2): PREADY at T+3.
- Each stall cycle adds one cycle.
- Timeout: PREADY occurs at T+TIMEOUT+2 when no response arrives. The counter starts at 0 at T+1.
- After a PREADY pulse, the bridge is in IDLE the next cycle. A back-to-back APB access, whose setup phase has PENABLE=0, is accepted with no dead cycle lost.
- wb_stb is never asserted outside REQ. wb_cyc is never asserted outside REQ or WAIT.

## Test plan

- **Read, zero wait:** defaults, no swap, read 0x04, slave acks at T+2 with 0x11223344 → wb_adr=1 and wb_sel=4'hF at T+1; PREADY=1 at T+3; PRDATA=0x11223344; PSLVERR=0.
- **Swapped write with stall:** SWAP_MASK=5'h18, SWAP_BASE=5'h18; write 0x18, data 0xAABBCCDD, PSTRB=4'b0011; 2 stall cycles → stb held 3 cycles; wb_dat_w=0xDDCCBBAA; wb_sel=4'b1100.
- **Swapped read:** address 0x1C, slave returns 0x01020304 → PRDATA=0x04030201.
- **Bus error:** wb_err at T+2 on a read → PREADY at T+3; PSLVERR=1; PRDATA=0. A following normal read returns PSLVERR=0.
- **Timeout:** TIMEOUT=8, slave silent → cyc drops and PREADY with PSLVERR=1 at T+10. A late ack at T+12 causes no PREADY.
- **Reset mid-transaction:** reset asserted while in WAIT → cyc, stb and PREADY are 0 next cycle. A subsequent access completes normally.
